// File: rtl/seven_segment_pkg.sv
// Shared types and segment patterns for the BCD seven-segment display path.
package seven_segment_pkg;

    typedef logic [6:0] segment_t;   // {g,f,e,d,c,b,a}, active-high
    typedef logic [3:0] bcd_digit_t;

    localparam segment_t SEG_0    = 7'h3F;
    localparam segment_t SEG_1    = 7'h06;
    localparam segment_t SEG_2    = 7'h5B;
    localparam segment_t SEG_3    = 7'h4F;
    localparam segment_t SEG_4    = 7'h66;
    localparam segment_t SEG_5    = 7'h6D;
    localparam segment_t SEG_6    = 7'h7D;
    localparam segment_t SEG_7    = 7'h07;
    localparam segment_t SEG_8    = 7'h7F;
    localparam segment_t SEG_9    = 7'h6F;
    localparam segment_t SEG_DASH = 7'h40;
    localparam segment_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seven_segment.sv
// Combinational BCD nibble to active-high segment pattern; non-decimal nibbles show a dash.
module bcd_to_seven_segment
    import seven_segment_pkg::*;
(
    input  bcd_digit_t digit,
    output segment_t   segments_c
);

    // Pattern lookup
    always_comb begin
        segments_c = SEG_DASH;
        case (digit)
            4'd0:    segments_c = SEG_0;
            4'd1:    segments_c = SEG_1;
            4'd2:    segments_c = SEG_2;
            4'd3:    segments_c = SEG_3;
            4'd4:    segments_c = SEG_4;
            4'd5:    segments_c = SEG_5;
            4'd6:    segments_c = SEG_6;
            4'd7:    segments_c = SEG_7;
            4'd8:    segments_c = SEG_8;
            4'd9:    segments_c = SEG_9;
            default: segments_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner with frame-synchronous double buffering
// and leading-zero blanking.
module bcd_seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int unsigned DIGITS_COUNT = 3,
    parameter int unsigned CLK_DIVIDER  = 50000,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic [0:DIGITS_COUNT*4-1] Bcd,
    input  logic                      BcdValid,
    input  logic                      Blank,
    output logic [6:0]                Segments,
    output logic [DIGITS_COUNT-1:0]   Anodes,
    output logic                      FrameDone
);

    localparam int unsigned BCD_W = DIGITS_COUNT * 4;
    localparam int unsigned CNT_W = $clog2(CLK_DIVIDER);
    localparam int unsigned IDX_W = $clog2(DIGITS_COUNT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIVIDER - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS_COUNT - 1);

    // XOR masks that both give the idle pattern and apply output polarity
    localparam segment_t                SEG_INACTIVE   = (ACTIVE_LOW != 0) ? 7'h7F : SEG_OFF;
    localparam logic [DIGITS_COUNT-1:0] ANODE_INACTIVE = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]        count_q,       count_d;
    logic [IDX_W-1:0]        index_q,       index_d;
    logic [0:BCD_W-1]        pending_q,     pending_d;
    logic                    pending_vld_q, pending_vld_d;
    logic [0:BCD_W-1]        display_q,     display_d;
    segment_t                segments_q,    segments_d;
    logic [DIGITS_COUNT-1:0] anodes_q,      anodes_d;
    logic                    frame_done_q,  frame_done_d;

    logic       tick_c;
    logic       boundary_c;
    bcd_digit_t sel_digit_c;
    segment_t   dec_seg_c;
    logic       blank_sel_c;
    logic       zero_run_c;

    assign tick_c     = (count_q == CNT_LAST);
    assign boundary_c = tick_c && (index_q == IDX_LAST);

    // Prescaler, digit index and double-buffered display value
    always_comb begin
        count_d       = count_q + CNT_W'(1);
        index_d       = index_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        display_d     = display_q;
        frame_done_d  = boundary_c;

        if (tick_c) begin
            count_d = '0;
            index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
        end

        if (boundary_c) begin
            if (BcdValid) begin
                display_d = Bcd;
            end else if (pending_vld_q) begin
                display_d = pending_q;
            end
            pending_vld_d = 1'b0;
        end else if (BcdValid) begin
            pending_d     = Bcd;
            pending_vld_d = 1'b1;
        end
    end

    // Select the upcoming digit and decide whether it is a suppressed leading zero
    always_comb begin
        sel_digit_c = '0;
        blank_sel_c = 1'b0;
        zero_run_c  = 1'b1;
        for (int unsigned i = 0; i < DIGITS_COUNT; i++) begin
            zero_run_c = zero_run_c && (display_d[i*4 +: 4] == 4'd0);
            if (IDX_W'(i) == index_d) begin
                sel_digit_c = display_d[i*4 +: 4];
                blank_sel_c = Blank && zero_run_c && (i != DIGITS_COUNT - 1);
            end
        end
    end

    bcd_to_seven_segment u_decoder (
        .digit      (sel_digit_c),
        .segments_c (dec_seg_c)
    );

    // Segments and anodes change together, only on a tick
    always_comb begin
        segments_d = segments_q;
        anodes_d   = anodes_q;
        if (tick_c) begin
            segments_d = (blank_sel_c ? SEG_OFF : dec_seg_c) ^ SEG_INACTIVE;
            anodes_d   = (DIGITS_COUNT'(1) << index_d) ^ ANODE_INACTIVE;
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count_q       <= '0;
            index_q       <= IDX_LAST;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            display_q     <= '0;
            segments_q    <= SEG_INACTIVE;
            anodes_q      <= ANODE_INACTIVE;
            frame_done_q  <= 1'b0;
        end else begin
            count_q       <= count_d;
            index_q       <= index_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            display_q     <= display_d;
            segments_q    <= segments_d;
            anodes_q      <= anodes_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign Segments  = segments_q;
    assign Anodes    = anodes_q;
    assign FrameDone = frame_done_q;

endmodule

// File: doc/bcd_seven_segment_scanner.md
# bcd_seven_segment_scanner

Time-multiplexed 7-segment display driver that consumes packed BCD digits from the binary-to-BCD converter and scans them onto a shared-segment, per-digit-enable display. It double-buffers the incoming value so a new number only appears at a frame boundary, which prevents tearing. It also performs leading-zero blanking and flags invalid BCD nibbles.

## Interface

Parameters:
- DIGITS_COUNT, 3, number of BCD digits and display positions (≥2)
- CLK_DIVIDER, 50000, clock cycles per digit dwell (≥2)
- ACTIVE_LOW, 1, 1 inverts Segments and Anodes (common-anode board); 0 gives active-high

Ports:
- Clk, input, 1, single clock; all state is on the rising edge
- nReset, input, 1, asynchronous, active-low reset
- Bcd, input, [0:DIGITS_COUNT*4-1], packed BCD; Bcd[0:3] is the most significant digit (digit 0), matching converter output order
- BcdValid, input, 1, capture strobe; Bcd is sampled on any cycle where it is high
- Blank, input, 1, enables leading-zero suppression
- Segments, output, 7, {g,f,e,d,c,b,a}, registered
- Anodes, output, DIGITS_COUNT, one-hot digit enable; bit i drives digit i; registered
- FrameDone, output, 1, single-cycle pulse after each display-register load

## Operation

- Prescaler counts 0..CLK_DIVIDER-1 and wraps. Tick is asserted when the count equals CLK_DIVIDER-1.
- Digit index range is 0..DIGITS_COUNT-1. On each tick it advances by one and wraps from DIGITS_COUNT-1 to 0.
- Frame boundary is a tick while index == DIGITS_COUNT-1.
- Capture: BcdValid=1 loads Bcd into the pending register and sets the pending flag. A later strobe overwrites the pending value (last wins).
- Display-register load at a frame boundary:
  - if BcdValid=1 in the boundary cycle, display ← Bcd directly;
  - else if the pending flag is set, display ← pending;
  - the pending flag clears in both cases;
  - if neither applies, display holds.
- FrameDone pulses on every boundary, whether or not the value changed.
- Digit decode (active-high encoding before polarity):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Nibbles 10–15 decode to a dash (40).
- Blanking: digit i is blanked (segments 00, anode still enabled) when all of these hold:
  - Blank=1;
  - display digits 0..i are all zero;
  - i ≠ DIGITS_COUNT-1. The last digit always shows, so a value of 0 displays as "0".
- A dash counts as non-zero and stops blanking.
- ACTIVE_LOW=1 inverts both Segments and Anodes at the output register.

## Timing

- Reset (asynchronous assert, synchronous release):
  - prescaler 0, index DIGITS_COUNT-1;
  - display all zeros, pending clear;
  - Anodes all off, Segments all off (both at inactive polarity);
  - FrameDone 0.
- First tick after reset is a frame boundary:
  - index → 0, display loads any pending value;
  - the cycle after the tick shows Anodes = digit 0 and the Segments for digit 0, with FrameDone=1.
- Segments and Anodes update together from the same register, one cycle after the tick. They never disagree for a cycle.
- Each digit is lit for exactly CLK_DIVIDER cycles. The frame period is DIGITS_COUNT*CLK_DIVIDER cycles.
- Bcd latency to display is at most one frame plus one cycle (strobe to boundary, then output register).
- nReset asserted mid-frame: everything returns to the reset values immediately; the pending value is discarded.
- Blank is sampled combinationally at each tick for the newly selected digit; a change takes effect on the next digit transition.

## Structure

- Package seven_segment_pkg holds:
  - segment pattern constants for 0–9, DASH and OFF;
  - a 7-bit segment typedef;
  - a 4-bit BCD digit typedef.
- Sub-module bcd_to_seven_segment: combinational nibble-to-pattern decoder, instantiated once and fed by the selected display digit.
- Top level holds the prescaler, index counter, pending/display registers, blanking logic and output registers.

## Test plan

All scenarios use DIGITS_COUNT=3, CLK_DIVIDER=4, ACTIVE_LOW=0.

- Reset then idle:
  - cycles 1–4 after release show Anodes=000, Segments=00;
  - after the first tick: Anodes=001, Segments=3F, FrameDone=1 for one cycle;
  - then 010, 100 at 4-cycle spacing.
- Strobe Bcd=0x123 mid-frame:
  - digits keep showing 0 until the boundary;
  - the next frame shows 06, 5B, 4F on Anodes 001, 010, 100.
- Blank=1 with display 0x007: digits 0 and 1 give 00 with their anodes lit, digit 2 gives 07. Display 0x000 gives 00, 00, 3F.
- Invalid nibble Bcd=0x1A5 gives 06, 40, 6D. With Blank=1 and 0x0A0, digit 0 is blank, then 40, then 3F.
- Simultaneous events:
  - strobe 0x111 two cycles before the boundary and 0x222 in the boundary cycle;
  - display gets 0x222; pending is clear afterwards, so the next boundary keeps 0x222.
- nReset asserted mid-frame with 0x456 pending: outputs go off asynchronously. After release the first frame shows 0x000.
